// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - pipeline-stage enable sequencer with stall, flush and in-flight count
// One token per accepted operation walks valid_q; stage k is enabled while its token is present and the pipe advances.
module stage_sequencer #(
   parameter  int NUM_STAGES = 4,
   localparam int CNT_W      = $clog2(NUM_STAGES + 1)
) (
   input  logic                  CLK,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  mode,
   input  logic                  stall,
   input  logic                  flush,
   output logic                  start_ready,
   output logic [NUM_STAGES-1:0] stage_en,
   output logic                  done,
   output logic                  busy,
   output logic [CNT_W-1:0]      inflight
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [NUM_STAGES-1:0] valid_q, valid_d;
   logic [CNT_W-1:0]      inflight_q, inflight_d;
   logic                  advance;
   logic                  accept;

   assign advance     = ~stall & ~flush;
   // Single-shot mode only admits a new op once the pipe has fully drained.
   assign start_ready = advance & (state_q != ST_FLUSH) & (mode | (valid_q == '0));
   assign accept      = start & start_ready;
   assign stage_en    = valid_q & {NUM_STAGES{advance}};
   assign done        = stage_en[NUM_STAGES-1];
   assign busy        = (state_q != ST_IDLE);
   assign inflight    = inflight_q;

   always_comb begin
      valid_d    = valid_q;
      inflight_d = inflight_q;
      if (flush) begin
         valid_d    = '0;
         inflight_d = '0;
      end else if (!stall) begin
         valid_d    = {valid_q[NUM_STAGES-2:0], accept};
         inflight_d = inflight_q + {{(CNT_W-1){1'b0}}, accept} - {{(CNT_W-1){1'b0}}, done};
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_FLUSH;
      end else begin
         case (state_q)
            ST_IDLE:  if (accept) state_d = ST_RUN;
            ST_RUN:   if (valid_d == '0) state_d = ST_IDLE;
            ST_FLUSH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         valid_q    <= '0;
         inflight_q <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         inflight_q <= inflight_d;
      end
   end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Parametrised pipeline-stage enable sequencer for the exponential datapath.
- Tracks operation tokens through NUM_STAGES register stages and drives one enable per stage, plus a completion pulse.
- Generalises the fixed 4-stage one-shot control with: configurable depth, single-shot or fully pipelined issue, global stall, synchronous flush, and in-flight count/status.
- Sits between the top-level request logic and the per-stage output registers.

Parameters:
- NUM_STAGES, 4, number of sequenced stages; legal range >= 2.
- CNT_W, $clog2(NUM_STAGES+1), width of the in-flight counter; derived, not overridden.

Ports:
- CLK  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  request to launch one operation.
- mode  in  1  issue mode: 0 = single-shot (one op at a time), 1 = pipelined (one op per cycle).
- stall  in  1  global hold; freezes all tokens.
- flush  in  1  discard all in-flight tokens.
- start_ready  out  1  start is accepted this cycle.
- stage_en  out  NUM_STAGES  per-stage register enable; bit k = stage k.
- done  out  1  final-stage completion pulse.
- busy  out  1  sequencer not idle.
- inflight  out  CNT_W  number of valid tokens.

Behaviour:
- **State:**
  - valid[NUM_STAGES-1:0] token shift register.
  - inflight counter.
  - FSM with states IDLE, RUN, FLUSH.
- **Reset** (rst_n low, asynchronous): valid=0, inflight=0, FSM=IDLE. Therefore stage_en=0, done=0, busy=0, and start_ready = ~stall & ~flush.
- **Accept:** accept = start & start_ready.
  - start_ready = ~flush & ~stall & (FSM!=FLUSH) & (mode | (valid==0)).
  - start while not ready is dropped, not queued.
- **Advance** (~stall & ~flush) at each edge: valid <= {valid[N-2:0], accept}.
- **Outputs** (combinational from registers, stall and flush):
  - stage_en = valid & {N{~stall & ~flush}}.
  - done = stage_en[N-1].
- **Latency:** with no stall, an accept in cycle t gives:
  - stage_en[k] high in cycle t+1+k;
  - done in cycle t+N.
  - Each stall cycle adds exactly one cycle of delay.
- **Issue rate:**
  - mode=1: one accept per cycle; back-to-back tokens occupy consecutive stages.
  - mode=0: next accept no earlier than cycle t+N+1, i.e. period N+1.
- **Mode change:** mode is sampled only in the accept term.
  - Switching 1->0 while tokens are in flight blocks new starts until valid==0.
  - In-flight tokens are never affected.
- **Stall:**
  - valid and inflight hold; FSM holds.
  - No accept, all stage_en=0, done=0.
  - busy unchanged.
- **Flush** has highest priority over start and stall.
  - In the cycle flush is high: stage_en=0, done=0, start_ready=0.
  - At the edge: valid<=0, inflight<=0, FSM<=FLUSH.
  - FLUSH lasts one cycle with busy=1 and start_ready=0, then goes to IDLE. It re-enters FLUSH if flush is still high.
- **inflight** update: inflight <= inflight + accept - done, unless flushing. It must always equal popcount(valid) and never exceeds NUM_STAGES.
- **FSM transitions:**
  - IDLE->RUN on accept.
  - RUN->IDLE at the edge where the next valid is all-zero.
  - In pipelined mode a simultaneous last-stage exit and new accept keeps RUN.
  - IDLE/RUN->FLUSH on flush.
  - FLUSH->IDLE otherwise.
- **Status:** busy = (FSM!=IDLE). busy=1 implies valid!=0 or FSM==FLUSH.
- **Reset mid-operation:** all tokens are lost immediately; no done is emitted for them.

Test Plan (NUM_STAGES=4):
1. **Reset and single-shot issue.** Release reset; mode=0; 1-cycle start in cycle 0.
   - stage_en = 0001, 0010, 0100, 1000 in cycles 1-4.
   - done in cycle 4; busy cycles 1-4; inflight=1 throughout.
   - start_ready low cycles 1-4, high from cycle 5.
2. **Single-shot blocking.** mode=0; start held high for 12 cycles from cycle 0.
   - Accepts in cycles 0, 5 and 10 only.
   - done in cycles 4 and 9.
3. **Pipelined back-to-back.** mode=1; start high cycles 0-5.
   - inflight = 1, 2, 3, 4, 4, 4 in cycles 1-6.
   - done every cycle 4-9.
   - stage_en=1111 in cycles 4-6.
   - busy drops in cycle 10.
4. **Stall.** mode=1; accept in cycle 0; stall high cycles 2-3.
   - stage_en=0 in cycles 2-3; valid frozen at 0010.
   - stage_en[1] re-asserts in cycle 4; done in cycle 6.
5. **Flush under load.** mode=1; 3 tokens in flight; flush with start=1 in cycle 5.
   - No accept and no done in cycle 5.
   - inflight=0 and FSM=FLUSH in cycle 6 (busy=1, start_ready=0).
   - IDLE in cycle 7; a new start in cycle 7 is accepted.
6. **Asynchronous reset mid-operation.** rst_n low in the middle of cycle 3 with tokens in flight.
   - Outputs go to reset values immediately; no done appears afterwards.
   - The counter matches popcount(valid) throughout.
